// File: rtl/collision_detector.sv
// Per-frame player/obstacle hit detector: scans one obstacle slot per clock after each frame tick.
// Optional lives counter and game-over latch are enabled by defining COLLISION_LIVES_EN.
module collision_detector #(
  parameter int NUM_OBST      = 4,
  parameter int nY            = 9,
  parameter int NUM_LANES     = 5,
  parameter int PLAYER_Y_POS  = 360,
  parameter int PLAYER_HEIGHT = 60,
  parameter int OBST_HEIGHT   = 40,
  parameter int START_LIVES   = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic [2:0]             player_lane,
  input  logic                   invincible,
  input  logic [NUM_OBST-1:0]    obst_active,
  input  logic [3*NUM_OBST-1:0]  obst_lane,
  input  logic [nY*NUM_OBST-1:0] obst_y,
  output logic                   collision,
  output logic [NUM_OBST-1:0]    obst_clear,
  output logic [2:0]             hit_index,
  output logic [1:0]             lives,
  output logic                   game_over,
  output logic                   scan_busy,
  output logic                   tick_overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // Vertical band limits widened by one bit so the obstacle bottom edge never wraps.
  localparam logic [nY:0] Y_TOP    = (nY+1)'(PLAYER_Y_POS);
  localparam logic [nY:0] Y_BOT    = (nY+1)'(PLAYER_Y_POS + PLAYER_HEIGHT);
  localparam logic [nY:0] OBST_H   = (nY+1)'(OBST_HEIGHT);
  localparam logic [3:0]  LANE_LIM = 4'(NUM_LANES);
  localparam logic [2:0]  LAST_IDX = 3'(NUM_OBST - 1);

  state_t        state;
  logic [2:0]    idx;
  logic          hit_found;
  logic [2:0]    hit_idx;

  logic          sel_active;
  logic [2:0]    sel_lane;
  logic [nY-1:0] sel_y;
  logic          slot_hit;
  logic          accept_hit;

  always_comb begin
    sel_active = 1'b0;
    sel_lane   = 3'd0;
    sel_y      = '0;
    for (int i = 0; i < NUM_OBST; i++) begin
      if (idx == 3'(i)) begin
        sel_active = obst_active[i];
        sel_lane   = obst_lane[3*i +: 3];
        sel_y      = obst_y[nY*i +: nY];
      end
    end
  end

  assign slot_hit = sel_active
                 && (sel_lane == player_lane)
                 && ({1'b0, sel_lane} < LANE_LIM)
                 && (({1'b0, sel_y} + OBST_H) > Y_TOP)
                 && ({1'b0, sel_y} < Y_BOT);

  assign accept_hit = (state == S_REPORT) && hit_found && !invincible;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      idx          <= 3'd0;
      hit_found    <= 1'b0;
      hit_idx      <= 3'd0;
      collision    <= 1'b0;
      obst_clear   <= '0;
      hit_index    <= 3'd0;
      scan_busy    <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      collision  <= 1'b0;
      obst_clear <= '0;
      case (state)
        S_IDLE: begin
          if (frame_tick && !game_over) begin
            idx       <= 3'd0;
            hit_found <= 1'b0;
            scan_busy <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (frame_tick) tick_overrun <= 1'b1;
          // First hit wins; later slots in the same scan are ignored.
          if (!hit_found && slot_hit) begin
            hit_found <= 1'b1;
            hit_idx   <= idx;
          end
          idx <= idx + 3'd1;
          if (idx == LAST_IDX) state <= S_REPORT;
        end
        S_REPORT: begin
          if (frame_tick) tick_overrun <= 1'b1;
          if (accept_hit) begin
            collision  <= 1'b1;
            obst_clear <= NUM_OBST'(1) << hit_idx;
            hit_index  <= hit_idx;
          end
          scan_busy <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          scan_busy <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef COLLISION_LIVES_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lives     <= 2'(START_LIVES);
      game_over <= 1'b0;
    end else if (accept_hit && (lives != 2'd0)) begin
      lives <= lives - 2'd1;
      if (lives == 2'd1) game_over <= 1'b1;
    end
  end
`else
  assign lives     = 2'(START_LIVES);
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Randomized and directed bench for collision_detector with a queue-based pulse scoreboard.
module tb_collision_detector;

  localparam int NUM_OBST = 4;
  localparam int NY       = 9;
  localparam int W        = 27;

  logic                   Clock;
  logic                   Reset;
  logic                   frame_tick;
  logic [2:0]             player_lane;
  logic                   invincible;
  logic [NUM_OBST-1:0]    obst_active;
  logic [3*NUM_OBST-1:0]  obst_lane;
  logic [NY*NUM_OBST-1:0] obst_y;
  logic                   collision;
  logic [NUM_OBST-1:0]    obst_clear;
  logic [2:0]             hit_index;
  logic [1:0]             lives;
  logic                   game_over;
  logic                   scan_busy;
  logic                   tick_overrun;

  collision_detector dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .player_lane  (player_lane),
    .invincible   (invincible),
    .obst_active  (obst_active),
    .obst_lane    (obst_lane),
    .obst_y       (obst_y),
    .collision    (collision),
    .obst_clear   (obst_clear),
    .hit_index    (hit_index),
    .lives        (lives),
    .game_over    (game_over),
    .scan_busy    (scan_busy),
    .tick_overrun (tick_overrun)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  int t_act[NUM_OBST];
  int t_lane[NUM_OBST];
  int t_y[NUM_OBST];
  int m_lives;
  bit m_go;
  bit m_overrun;
  int m_hit_index;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Lowest-index slot that overlaps the player's band in the player's (legal) lane.
  task automatic model_scan(output bit hit, output int hidx);
    hit  = 1'b0;
    hidx = 0;
    for (int i = 0; i < NUM_OBST; i++) begin
      if (!hit && t_act[i] != 0 && t_lane[i] == int'(player_lane) && t_lane[i] < 5
          && t_y[i] + 40 > 360 && t_y[i] < 360 + 60) begin
        hit  = 1'b1;
        hidx = i;
      end
    end
  endtask

  task automatic model_reset();
    m_lives     = 3;
    m_go        = 1'b0;
    m_overrun   = 1'b0;
    m_hit_index = 0;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NUM_OBST; i++) begin
      t_act[i]  = 0;
      t_lane[i] = 0;
      t_y[i]    = 0;
    end
  endtask

  task automatic drive_slots();
    for (int i = 0; i < NUM_OBST; i++) begin
      obst_active[i]        = (t_act[i] != 0);
      obst_lane[3*i +: 3]   = 3'(t_lane[i]);
      obst_y[NY*i +: NY]    = NY'(t_y[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_collision"}, collision, 0);
    check({tag, "_obst_clear"}, obst_clear, 0);
    check({tag, "_hit_index"}, hit_index, 0);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_scan_busy"}, scan_busy, 0);
    check({tag, "_tick_overrun"}, tick_overrun, 0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset      = 1'b1;
    frame_tick = 1'b0;
    @(negedge Clock);
    check_reset_values("reset");
    Reset = 1'b0;
    model_reset();
  endtask

  // One frame: tick in cycle 0, optional second tick in cycle extra_at, checks at cycle NUM_OBST+2.
  task automatic run_scan(input bit inv, input int extra_at);
    int c0;
    bit hit;
    int hidx;
    bit accepted;
    @(negedge Clock);
    drive_slots();
    invincible = inv;
    frame_tick = 1'b1;
    c0 = cyc;
    model_scan(hit, hidx);
    accepted = !m_go;
    if (accepted && extra_at > 0) m_overrun = 1'b1;
    if (accepted && hit && !inv) begin
`ifdef COLLISION_LIVES_EN
      if (m_lives > 0) m_lives--;
      if (m_lives == 0) m_go = 1'b1;
`endif
      m_hit_index = hidx;
      exp_q.push_back({16'(c0 + NUM_OBST + 2), 1'b1, 4'(1 << hidx), 3'(hidx), 2'(m_lives), m_go});
    end
    @(negedge Clock);
    frame_tick = 1'b0;
    check("scan_busy_start", scan_busy, accepted);
    for (int k = 2; k <= NUM_OBST + 2; k++) begin
      @(negedge Clock);
      frame_tick = (k == extra_at);
    end
    check("scan_busy_end", scan_busy, 0);
    check("lives", lives, m_lives);
    check("game_over", game_over, m_go);
    check("hit_index", hit_index, m_hit_index);
    check("tick_overrun", tick_overrun, m_overrun);
  endtask

  // A scan with a hit aborted by Reset in cycle 3 must never produce a pulse.
  task automatic reset_mid_scan();
    int c0;
    @(negedge Clock);
    drive_slots();
    invincible = 1'b0;
    frame_tick = 1'b1;
    c0 = cyc;
    @(negedge Clock);
    frame_tick = 1'b0;
    while (cyc < c0 + 3) @(negedge Clock);
    Reset = 1'b1;
    while (cyc < c0 + NUM_OBST + 2) @(negedge Clock);
    check_reset_values("mid_reset");
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    repeat (NUM_OBST + 3) @(negedge Clock);
    check("mid_reset_busy_after", scan_busy, 0);
  endtask

  // monitor: every pulse must match the oldest expectation, including its cycle
  always @(negedge Clock) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (collision || obst_clear != '0) begin
      act = {16'(cyc), collision, obst_clear, hit_index, lives, game_over};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(act), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse", 32'(act), 32'(e));
      end
    end
  end

  int y_tab[8] = '{320, 321, 419, 420, 330, 350, 0, 511};

  initial begin
    Reset       = 1'b1;
    frame_tick  = 1'b0;
    player_lane = 3'd2;
    invincible  = 1'b0;
    obst_active = '0;
    obst_lane   = '0;
    obst_y      = '0;
    clear_slots();
    model_reset();
    repeat (2) @(negedge Clock);
    check_reset_values("power_on");
    Reset = 1'b0;

    // basic hit on slot 1
    player_lane = 3'd2;
    t_act[1] = 1; t_lane[1] = 2; t_y[1] = 330;
    run_scan(1'b0, 0);

    // priority: slots 0 and 3 both hit
    do_reset();
    clear_slots();
    t_act[0] = 1; t_lane[0] = 2; t_y[0] = 400;
    t_act[3] = 1; t_lane[3] = 2; t_y[3] = 350;
    run_scan(1'b0, 0);

    // vertical band boundaries
    for (int b = 0; b < 4; b++) begin
      do_reset();
      clear_slots();
      t_act[2] = 1; t_lane[2] = 2; t_y[2] = y_tab[b];
      run_scan(1'b0, 0);
    end

    // illegal lane never hits even if equal to player lane
    do_reset();
    clear_slots();
    player_lane = 3'd6;
    t_act[0] = 1; t_lane[0] = 6; t_y[0] = 350;
    run_scan(1'b0, 0);
    player_lane = 3'd2;

    // invincible discards a valid hit
    do_reset();
    clear_slots();
    t_act[1] = 1; t_lane[1] = 2; t_y[1] = 350;
    run_scan(1'b1, 0);

    // lives run-down; fourth tick is ignored when lives are enabled
    do_reset();
    for (int n = 0; n < 4; n++) run_scan(1'b0, 0);

    // overlapping tick during a scan
    do_reset();
    run_scan(1'b0, 3);

    // reset in the middle of a scan
    do_reset();
    reset_mid_scan();

    // randomized frames
    do_reset();
    for (int r = 0; r < 48; r++) begin
      if (r % 8 == 7) do_reset();
      player_lane = 3'($urandom_range(0, 7));
      for (int i = 0; i < NUM_OBST; i++) begin
        t_act[i]  = int'($urandom_range(0, 3) != 0);
        t_lane[i] = ($urandom_range(0, 1) == 1) ? int'(player_lane) : int'($urandom_range(0, 7));
        t_y[i]    = ($urandom_range(0, 2) != 0) ? y_tab[$urandom_range(0, 7)] : int'($urandom_range(0, 511));
      end
      run_scan($urandom_range(0, 3) == 0, ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, NUM_OBST + 1)) : 0);
    end

    repeat (4) @(negedge Clock);
    check("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
# collision_detector

Per-frame hit detector between the player sprite and the falling obstacles. On each frame tick it scans every obstacle slot one per clock and picks the lowest-index obstacle that shares the player's lane and overlaps the player's vertical band. It then issues a single-cycle `collision` pulse to the player drawer, a one-hot retire pulse to the obstacle bank, and a lives/game-over update. It sits between the obstacle generator and the player drawer (its `collision` output drives the player drawer's `collision` input).

## Interface
Parameters:
- `NUM_OBST`, 4: obstacle slots scanned per frame (1–8).
- `nY`, 9: y-coordinate width.
- `NUM_LANES`, 5: lanes; legal lane values are 0..NUM_LANES-1.
- `PLAYER_Y_POS`, 360: player top row.
- `PLAYER_HEIGHT`, 60: player sprite height.
- `OBST_HEIGHT`, 40: obstacle sprite height.
- `START_LIVES`, 3: lives after reset (1–3).

Ports:
- `Clock`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `frame_tick`  in  1  one-cycle pulse that starts a scan.
- `player_lane`  in  3  current player lane.
- `invincible`  in  1  player drawer's collision-mode flag.
- `obst_active`  in  NUM_OBST  slot i is live when bit i = 1.
- `obst_lane`  in  3*NUM_OBST  slot i lane in bits [3i+2:3i].
- `obst_y`  in  nY*NUM_OBST  slot i top row in bits [nY*i+nY-1:nY*i].
- `collision`  out  1  one-cycle hit pulse.
- `obst_clear`  out  NUM_OBST  one-hot, one-cycle retire pulse for the hit slot.
- `hit_index`  out  3  slot of the last accepted hit; holds its value.
- `lives`  out  2  remaining lives.
- `game_over`  out  1  sticky; set when `lives` reaches 0.
- `scan_busy`  out  1  high in the SCAN and REPORT states.
- `tick_overrun`  out  1  sticky; a `frame_tick` arrived while busy.

## Operation
- States:
  - IDLE: on `frame_tick` && !`game_over`, set idx=0, clear `hit_found`, go to SCAN.
  - SCAN: evaluate slot idx. If no hit is latched yet and the slot hits, latch `hit_found` and `hit_idx`=idx. Increment idx. Go to REPORT after idx = NUM_OBST-1.
  - REPORT: one cycle, then go to IDLE.
- Hit test for slot i, all conditions required:
  - `obst_active[i]`;
  - `obst_lane[i]` == `player_lane`;
  - `obst_y[i]` + OBST_HEIGHT > PLAYER_Y_POS;
  - `obst_y[i]` < PLAYER_Y_POS + PLAYER_HEIGHT.
- Compute the sums in nY+1 bits so there is no wrap. Slots with lane ≥ NUM_LANES never hit.
- Priority: the lowest index wins. Later hits in the same scan are ignored.
- REPORT, with `hit_found` && !`invincible`:
  - register `collision`=1 and `obst_clear`=1<<hit_idx;
  - `hit_index`=hit_idx;
  - `lives` decrements, saturating at 0; `lives` becoming 0 sets `game_over`.
- REPORT, with `hit_found` && `invincible`: the hit is discarded. No pulse, no clear, no lives change.
- Inputs are sampled live each SCAN cycle. Upstream holds them stable for NUM_OBST+1 cycles after `frame_tick`.
- `frame_tick` in SCAN/REPORT: ignored, and sets `tick_overrun`.
- `frame_tick` while `game_over`: ignored, and `tick_overrun` is not set.
- `game_over` and `tick_overrun` clear only on `Reset`.

## Timing
- Reset values: state IDLE, `collision`=0, `obst_clear`=0, `hit_index`=0, `lives`=START_LIVES, `game_over`=0, `scan_busy`=0, `tick_overrun`=0.
- With `frame_tick` high in cycle 0:
  - SCAN occupies cycles 1..NUM_OBST;
  - REPORT is cycle NUM_OBST+1;
  - `collision`/`obst_clear` are high in cycle NUM_OBST+2 only (cycle 6 at the defaults).
- `scan_busy` is high in cycles 1..NUM_OBST+1. The earliest next accepted tick is cycle NUM_OBST+2.
- `invincible` is sampled in the REPORT cycle.
- `lives`, `game_over` and `hit_index` update in the same cycle `collision` rises.
- All outputs are registered.
- `Reset` mid-scan aborts immediately. No pulse is emitted afterwards.

## Configuration
- `COLLISION_LIVES_EN` defined:
  - lives counter and `game_over` behave as above.
- `COLLISION_LIVES_EN` undefined:
  - `lives` is constant START_LIVES;
  - `game_over` is constant 0;
  - scans run on every tick without limit;
  - `collision`, `obst_clear`, `hit_index` and `tick_overrun` are unchanged.

## Test plan
- Defaults; player_lane=2; slot1 active, lane 2, y=330; tick at cycle 0 → `collision` and `obst_clear`=4'b0010 in cycle 6 only; `hit_index`=1; `lives`=2.
- Slots 0 and 3 both hitting (lane 2, y=400 and y=350) → only `obst_clear`=4'b0001, `hit_index`=0.
- Boundaries: y=320 (320+40=360, not >360) → no hit; y=321 → hit; y=419 → hit; y=420 → no hit.
- `invincible`=1 through REPORT with a valid hit → no `collision`, no `obst_clear`, `lives` stays 3.
- Three accepted hits (macro defined) → `lives` goes 3→2→1→0, `game_over`=1 with the third pulse; a fourth tick is ignored and `scan_busy` stays 0. With the macro undefined, `lives` stays 3.
- Tick at cycle 0, second tick at cycle 3 → `tick_overrun`=1, a single scan runs. `Reset` asserted at cycle 3 → no pulse in cycle 6, all outputs at their reset values.
